idivsqrt_radix: RTL and testbench
=================================

# idivsqrt_radix

Parametrised iterative integer divide / remainder / square-root unit for the integer execute path, alongside the floating-point divide/sqrt datapath. Each cycle it retires K quotient or root bits using a chained restoring recurrence. It accepts one operation at a time through a ready/valid handshake and carries an opaque tag. Results are held under back-pressure until consumed.

## Interface
- XLEN, 64: operand/result width; must be divisible by 2·K
- K, 2: bits retired per iteration cycle; legal values 1, 2, 4
- TAGW, 5: width of the pass-through tag
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- FlushE  in  1  kill in-flight operation
- StartE  in  1  request valid
- ReadyE  out  1  unit can accept a request
- SignedE  in  1  signed operands (ignored for sqrt)
- RemE  in  1  return remainder instead of quotient/root
- SqrtE  in  1  integer square root of AE (BE ignored)
- AE, BE  in  XLEN  dividend/radicand, divisor
- TagE  in  TAGW  tag returned with result
- BusyE  out  1  iteration in progress
- ValidM  out  1  result valid
- ReadyM  in  1  consumer accepts result
- ResultM  out  XLEN  quotient, remainder or root
- TagM  out  TAGW  tag of ResultM
- DivZeroM  out  1  divisor was zero (0 for sqrt)

## Operation
- States: IDLE, BUSY, DONE. ReadyE = (state==IDLE); BusyE = (state==BUSY); ValidM = (state==DONE).
- IDLE, StartE=1: latch TagE, |AE|, |BE| (absolute values only when SignedE), quotient and result signs, and iteration count. The count is N=XLEN/K for divide and XLEN/(2K) for sqrt.
  - Special cases go to DONE directly; otherwise go to BUSY.
- Divide special cases:
  - BE=0: quotient all ones; remainder = AE; DivZeroM=1.
  - Signed AE=−2^(XLEN−1), BE=−1: quotient = AE; remainder = 0.
- BUSY: K restoring steps per cycle, each a compare/subtract on an (XLEN+1)-bit partial remainder. The counter decrements; at count 1 the next state is DONE.
- Result formation on the BUSY→DONE edge:
  - Quotient is negated if operand signs differ.
  - Remainder takes the dividend's sign.
  - Sqrt returns floor(sqrt(AE)) unsigned; remainder = AE − root².
- DONE: ResultM, TagM and DivZeroM are held stable. ValidM && ReadyM → IDLE.
- FlushE=1 in any state → IDLE on the next edge; no result is produced. FlushE has priority over StartE and ReadyM.
- StartE while ReadyE=0 is ignored. The requester must hold the request.
- Reset mid-operation equals flush plus output clear.

## Timing
- Request accepted at edge T.
- Divide: ValidM is first high in cycle T+N+1 (N=XLEN/K).
- Sqrt: ValidM is first high in cycle T+XLEN/(2K)+1.
- Special cases: ValidM is high in cycle T+1.
- ReadyE returns high the cycle after the ValidM&&ReadyM handshake. Minimum issue interval is latency+1.
- Reset values: state IDLE, ReadyE=1, BusyE=0, ValidM=0, ResultM=0, TagM=0, DivZeroM=0, counter=0.

## Configuration
- IDIVSQRT_SQRT_EN defined: sqrt datapath and root recurrence are compiled in, as above.
- IDIVSQRT_SQRT_EN undefined: sqrt hardware is removed. A request with SqrtE=1 goes directly to DONE at T+1 with ResultM=0, DivZeroM=0 and its tag returned. Divide behaviour is unchanged.

## Test plan
XLEN=64, K=2, so N=32.
- Unsigned divide: AE=100, BE=7, RemE=0 → ResultM=14 in cycle T+33. With RemE=1 → ResultM=2.
- Signed divide: AE=−7, BE=2 → quotient 0xFFFF_FFFF_FFFF_FFFD, remainder 0xFFFF_FFFF_FFFF_FFFF.
- Divide by zero: AE=5, BE=0, unsigned → ResultM=0xFFFF_FFFF_FFFF_FFFF and DivZeroM=1 in cycle T+1. Remainder op → ResultM=5.
- Signed overflow: AE=0x8000_0000_0000_0000, BE=−1 → quotient 0x8000_0000_0000_0000, remainder 0, in cycle T+1.
- Sqrt (macro defined): AE=1000 → root 31, remainder 39, ValidM in cycle T+17.
  - Repeat with FlushE at T+5 → no ValidM; ReadyE=1 in cycle T+6.
- Back-pressure: hold ReadyM=0 for 3 cycles after ValidM → ResultM/TagM stable, ReadyE=0. Then ReadyM=1 → ReadyE=1 the next cycle, and an immediately issued request with TagE=9 returns TagM=9.

Source files
------------

// File: rtl/idivsqrt_radix.sv
// Iterative integer divide/remainder/sqrt, K result bits retired per cycle by a restoring recurrence.
// Optional macro IDIVSQRT_SQRT_EN compiles in the square-root datapath.
module idivsqrt_radix #(
  parameter int XLEN = 64,
  parameter int K    = 2,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            StartE,
  output logic            ReadyE,
  input  logic            SignedE,
  input  logic            RemE,
  input  logic            SqrtE,
  input  logic [XLEN-1:0] AE,
  input  logic [XLEN-1:0] BE,
  input  logic [TAGW-1:0] TagE,
  output logic            BusyE,
  output logic            ValidM,
  input  logic            ReadyM,
  output logic [XLEN-1:0] ResultM,
  output logic [TAGW-1:0] TagM,
  output logic            DivZeroM
);

  localparam int N_DIV  = XLEN / K;
  localparam int N_SQRT = XLEN / (2 * K);
  localparam int CW     = $clog2(N_DIV + 1);
  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, acc_d;   // dividend/radicand shifting out, quotient shifting in
  logic [XLEN-1:0] rem_q, rem_d;   // partial remainder
  logic [XLEN-1:0] div_q, div_d;   // divisor, or the developing root in sqrt mode
  logic            negq_q, negr_q, rem_sel_q, divzero_q;
  logic [XLEN-1:0] result_q;
  logic [TAGW-1:0] tag_q;
`ifdef IDIVSQRT_SQRT_EN
  logic            sqrt_q;
  logic [XLEN:0]   trial_s;
`endif

  logic            a_neg_s, b_neg_s, div0_s, ovf_s;
  logic [XLEN-1:0] a_abs_s, b_abs_s;
  logic [XLEN:0]   p_s;
  logic [XLEN-1:0] quo_s, rmd_s, fin_s;

  assign ReadyE   = (state_q == IDLE);
  assign BusyE    = (state_q == BUSY);
  assign ValidM   = (state_q == DONE);
  assign ResultM  = result_q;
  assign TagM     = tag_q;
  assign DivZeroM = divzero_q;

  // Request decode: operand magnitudes and special-case detection
  always_comb begin
    a_neg_s = SignedE & AE[XLEN-1];
    b_neg_s = SignedE & BE[XLEN-1];
    a_abs_s = a_neg_s ? (ZERO - AE) : AE;
    b_abs_s = b_neg_s ? (ZERO - BE) : BE;
    div0_s  = (BE == ZERO);
    ovf_s   = SignedE & (AE == MINV) & (BE == ONES);
  end

  // K chained restoring steps plus final sign fix-up
  always_comb begin
    p_s   = {1'b0, rem_q};
    acc_d = acc_q;
    div_d = div_q;
`ifdef IDIVSQRT_SQRT_EN
    trial_s = {(XLEN+1){1'b0}};
`endif
    for (int i = 0; i < K; i++) begin
`ifdef IDIVSQRT_SQRT_EN
      if (sqrt_q) begin
        p_s     = {p_s[XLEN-2:0], acc_d[XLEN-1:XLEN-2]};
        acc_d   = {acc_d[XLEN-3:0], 2'b00};
        trial_s = {div_d[XLEN-2:0], 2'b01};
        if (p_s >= trial_s) begin
          p_s   = p_s - trial_s;
          div_d = {div_d[XLEN-2:0], 1'b1};
        end else begin
          div_d = {div_d[XLEN-2:0], 1'b0};
        end
      end else begin
`endif
        p_s   = {p_s[XLEN-1:0], acc_d[XLEN-1]};
        acc_d = {acc_d[XLEN-2:0], 1'b0};
        if (p_s >= {1'b0, div_d}) begin
          p_s      = p_s - {1'b0, div_d};
          acc_d[0] = 1'b1;
        end else begin
          acc_d[0] = 1'b0;
        end
`ifdef IDIVSQRT_SQRT_EN
      end
`endif
    end
    rem_d = p_s[XLEN-1:0];
    rmd_s = negr_q ? (ZERO - rem_d) : rem_d;
`ifdef IDIVSQRT_SQRT_EN
    quo_s = sqrt_q ? div_d : (negq_q ? (ZERO - acc_d) : acc_d);
`else
    quo_s = negq_q ? (ZERO - acc_d) : acc_d;
`endif
    fin_s = rem_sel_q ? rmd_s : quo_s;
  end

  // Control FSM and all datapath/output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      acc_q     <= ZERO;
      rem_q     <= ZERO;
      div_q     <= ZERO;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      divzero_q <= 1'b0;
      result_q  <= ZERO;
      tag_q     <= {TAGW{1'b0}};
`ifdef IDIVSQRT_SQRT_EN
      sqrt_q    <= 1'b0;
`endif
    end else if (FlushE) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (StartE) begin
            tag_q     <= TagE;
            rem_sel_q <= RemE;
            rem_q     <= ZERO;
            if (SqrtE) begin
`ifdef IDIVSQRT_SQRT_EN
              sqrt_q    <= 1'b1;
              acc_q     <= AE;
              div_q     <= ZERO;
              negq_q    <= 1'b0;
              negr_q    <= 1'b0;
              cnt_q     <= CW'(N_SQRT);
              state_q   <= BUSY;
`else
              result_q  <= ZERO;
              divzero_q <= 1'b0;
              state_q   <= DONE;
`endif
            end else if (div0_s) begin
              result_q  <= RemE ? AE : ONES;
              divzero_q <= 1'b1;
              state_q   <= DONE;
            end else if (ovf_s) begin
              result_q  <= RemE ? ZERO : AE;
              divzero_q <= 1'b0;
              state_q   <= DONE;
            end else begin
`ifdef IDIVSQRT_SQRT_EN
              sqrt_q    <= 1'b0;
`endif
              acc_q     <= a_abs_s;
              div_q     <= b_abs_s;
              negq_q    <= a_neg_s ^ b_neg_s;
              negr_q    <= a_neg_s;
              cnt_q     <= CW'(N_DIV);
              state_q   <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          div_q <= div_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q  <= fin_s;
            divzero_q <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (ReadyM) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idivsqrt_radix.sv
// Self-checking bench for idivsqrt_radix: directed table, random vectors vs. arithmetic model,
// flush, reset and back-pressure sequences.
module tb_idivsqrt_radix;

  localparam int LAT_DIV = 64 / 2 + 1;
  localparam int LAT_SQ  = 64 / 4 + 1;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        sgn;
    logic        rem;
    logic        sqrt;
    logic [4:0]  tag;
    logic [63:0] res;
    logic        dz;
    logic [7:0]  lat;
  } vec_t;

  logic        clk, reset, FlushE, StartE, ReadyE, SignedE, RemE, SqrtE;
  logic [63:0] AE, BE, ResultM;
  logic [4:0]  TagE, TagM;
  logic        BusyE, ValidM, ReadyM, DivZeroM;

  int nvec  = 0;
  int nfail = 0;

  idivsqrt_radix dut (
    .clk(clk), .reset(reset), .FlushE(FlushE), .StartE(StartE), .ReadyE(ReadyE),
    .SignedE(SignedE), .RemE(RemE), .SqrtE(SqrtE), .AE(AE), .BE(BE), .TagE(TagE),
    .BusyE(BusyE), .ValidM(ValidM), .ReadyM(ReadyM), .ResultM(ResultM), .TagM(TagM),
    .DivZeroM(DivZeroM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: SV signed/unsigned division and a greedy bit-by-bit root search
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic signed [63:0] sa, sb, sr;
    r = v;
    sa = v.a;
    sb = v.b;
    if (v.sqrt) begin
`ifdef IDIVSQRT_SQRT_EN
      begin
        logic [63:0] root, cand;
        root = 64'd0;
        for (int bt = 31; bt >= 0; bt--) begin
          cand = root | (64'd1 << bt);
          if (cand * cand <= v.a) root = cand;
        end
        r.res = v.rem ? (v.a - root * root) : root;
        r.dz  = 1'b0;
        r.lat = 8'(LAT_SQ);
      end
`else
      r.res = 64'd0;
      r.dz  = 1'b0;
      r.lat = 8'd1;
`endif
    end else if (v.b == 64'd0) begin
      r.res = v.rem ? v.a : ONES;
      r.dz  = 1'b1;
      r.lat = 8'd1;
    end else if (v.sgn && v.a == MINV && v.b == ONES) begin
      r.res = v.rem ? 64'd0 : v.a;
      r.dz  = 1'b0;
      r.lat = 8'd1;
    end else begin
      if (v.sgn) begin
        sr = v.rem ? (sa % sb) : (sa / sb);
        r.res = sr;
      end else begin
        r.res = v.rem ? (v.a % v.b) : (v.a / v.b);
      end
      r.dz  = 1'b0;
      r.lat = 8'(LAT_DIV);
    end
    return r;
  endfunction

  task automatic wait_ready(input string nm);
    int w;
    w = 0;
    while (!ReadyE && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " ReadyE"}, 64'(ReadyE), 64'd1);
  endtask

  task automatic issue(input vec_t v);
    AE = v.a; BE = v.b; SignedE = v.sgn; RemE = v.rem; SqrtE = v.sqrt; TagE = v.tag;
    StartE = 1'b1;
    @(negedge clk);
    StartE = 1'b0;
    AE = {$urandom, $urandom};
    BE = {$urandom, $urandom};
    TagE = 5'($urandom);
  endtask

  task automatic run_op(input string nm, input vec_t v);
    int cyc;
    wait_ready(nm);
    issue(v);
    cyc = 1;
    if (v.lat > 8'd1) chk({nm, " BusyE"}, 64'(BusyE), 64'd1);
    while (!ValidM && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'(v.lat));
    chk({nm, " ResultM"}, ResultM, v.res);
    chk({nm, " DivZeroM"}, 64'(DivZeroM), 64'(v.dz));
    chk({nm, " TagM"}, 64'(TagM), 64'(v.tag));
    @(negedge clk);
  endtask

  vec_t tbl[12];
  vec_t v;
  int   cyc, seen;

  initial begin
    tbl[0]  = '{64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 5'd1, 64'd14, 1'b0, 8'(LAT_DIV)};
    tbl[1]  = '{64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 5'd2, 64'd2, 1'b0, 8'(LAT_DIV)};
    tbl[2]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 5'd3,
                64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 8'(LAT_DIV)};
    tbl[3]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 5'd4,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'(LAT_DIV)};
    tbl[4]  = '{64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 5'd5, ONES, 1'b1, 8'd1};
    tbl[5]  = '{64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 5'd6, 64'd5, 1'b1, 8'd1};
    tbl[6]  = '{MINV, ONES, 1'b1, 1'b0, 1'b0, 5'd7, MINV, 1'b0, 8'd1};
    tbl[7]  = '{MINV, ONES, 1'b1, 1'b1, 1'b0, 5'd8, 64'd0, 1'b0, 8'd1};
`ifdef IDIVSQRT_SQRT_EN
    tbl[8]  = '{64'd1000, 64'd0, 1'b0, 1'b0, 1'b1, 5'd9, 64'd31, 1'b0, 8'(LAT_SQ)};
    tbl[9]  = '{64'd1000, 64'd5, 1'b1, 1'b1, 1'b1, 5'd10, 64'd39, 1'b0, 8'(LAT_SQ)};
`else
    tbl[8]  = '{64'd1000, 64'd0, 1'b0, 1'b0, 1'b1, 5'd9, 64'd0, 1'b0, 8'd1};
    tbl[9]  = '{64'd1000, 64'd5, 1'b1, 1'b1, 1'b1, 5'd10, 64'd0, 1'b0, 8'd1};
`endif
    tbl[10] = '{MINV, ONES, 1'b0, 1'b0, 1'b0, 5'd11, 64'd0, 1'b0, 8'(LAT_DIV)};
    tbl[11] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b1, 1'b1, 1'b0, 5'd12,
                64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 8'd1};

    reset = 1'b1; FlushE = 1'b0; StartE = 1'b0; SignedE = 1'b0; RemE = 1'b0; SqrtE = 1'b0;
    AE = 64'd0; BE = 64'd0; TagE = 5'd0; ReadyM = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset ReadyE", 64'(ReadyE), 64'd1);
    chk("reset BusyE", 64'(BusyE), 64'd0);
    chk("reset ValidM", 64'(ValidM), 64'd0);
    chk("reset ResultM", ResultM, 64'd0);
    chk("reset TagM", 64'(TagM), 64'd0);
    chk("reset DivZeroM", 64'(DivZeroM), 64'd0);

    for (int i = 0; i < 12; i++) run_op($sformatf("tbl[%0d]", i), tbl[i]);

    for (int i = 0; i < 60; i++) begin
      v = '0;
      v.a    = {$urandom, $urandom} >> $urandom_range(0, 60);
      v.sgn  = 1'($urandom);
      v.rem  = 1'($urandom);
      v.sqrt = ($urandom_range(0, 3) == 0);
      v.tag  = 5'($urandom);
      case ($urandom_range(0, 4))
        0: v.b = 64'd0;
        1: v.b = 64'($urandom_range(1, 20));
        2: v.b = ONES - 64'($urandom_range(0, 20));
        3: v.b = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: v.b = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 3) == 0) v.a = ONES - v.a;
      v = model(v);
      run_op($sformatf("rand[%0d]", i), v);
    end

    // Flush four cycles into an iterating op: no result, ready next cycle
    wait_ready("flush");
`ifdef IDIVSQRT_SQRT_EN
    issue('{64'd1000, 64'd0, 1'b0, 1'b0, 1'b1, 5'd13, 64'd0, 1'b0, 8'd0});
`else
    issue('{64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 5'd13, 64'd0, 1'b0, 8'd0});
`endif
    seen = 0;
    for (cyc = 1; cyc < 5; cyc++) begin
      if (ValidM) seen++;
      @(negedge clk);
    end
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    chk("flush ReadyE", 64'(ReadyE), 64'd1);
    chk("flush BusyE", 64'(BusyE), 64'd0);
    for (int i = 0; i < 40; i++) begin
      if (ValidM) seen++;
      @(negedge clk);
    end
    chk("flush no ValidM", 64'(seen), 64'd0);
    run_op("after flush", model('{64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 5'd14, 64'd0, 1'b0, 8'd0}));

    // Back-pressure: result and tag held while the consumer stalls
    ReadyM = 1'b0;
    wait_ready("bp");
    issue('{64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 5'd3, 64'd0, 1'b0, 8'd0});
    cyc = 1;
    while (!ValidM && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp latency", 64'(cyc), 64'(LAT_DIV));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp ValidM %0d", i), 64'(ValidM), 64'd1);
      chk($sformatf("bp ResultM %0d", i), ResultM, 64'd14);
      chk($sformatf("bp TagM %0d", i), 64'(TagM), 64'd3);
      chk($sformatf("bp ReadyE %0d", i), 64'(ReadyE), 64'd0);
      @(negedge clk);
    end
    ReadyM = 1'b1;
    @(negedge clk);
    chk("bp release ReadyE", 64'(ReadyE), 64'd1);
    chk("bp release ValidM", 64'(ValidM), 64'd0);
    run_op("bp next", '{64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 5'd9, ONES, 1'b1, 8'd1});

    // Reset in the middle of an iteration clears outputs
    wait_ready("midreset");
    issue('{64'd12345, 64'd6, 1'b0, 1'b0, 1'b0, 5'd21, 64'd0, 1'b0, 8'd0});
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset ReadyE", 64'(ReadyE), 64'd1);
    chk("midreset BusyE", 64'(BusyE), 64'd0);
    chk("midreset ResultM", ResultM, 64'd0);
    chk("midreset TagM", 64'(TagM), 64'd0);
    chk("midreset DivZeroM", 64'(DivZeroM), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ValidM) seen++;
      @(negedge clk);
    end
    chk("midreset no ValidM", 64'(seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
